seg_decoder: RTL and testbench
==============================

SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, meaning the consecutive identical samples required before decode (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port seg_a  input  7  tens-digit segments, bit6=a .. bit0=g, active-high.
REQ-005 SHALL have port seg_b  input  7  ones-digit segments, same encoding.
REQ-006 SHALL have port seg_valid  input  1  the seg_a/seg_b pair is meaningful this cycle.
REQ-007 SHALL have port amount  output  5  last successfully decoded amount, 0..31.
REQ-008 SHALL have port amount_valid  output  1  one-cycle pulse when amount is updated.
REQ-009 SHALL have port decode_err  output  1  one-cycle pulse when a filtered pair fails decode.
REQ-010 SHALL have port busy  output  1  high while in FILTER or DECODE.

Function
REQ-011 SHALL map patterns to digits exactly: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; any other pattern, including 0000000, is invalid.
REQ-012 SHALL compute value = tens*10 + ones with no truncation; result is legal only if both digits are valid and value <= 31.
REQ-013 SHALL implement states IDLE, FILTER, DECODE, HOLD.
REQ-014 IDLE: on seg_valid=1, SHALL latch {seg_a,seg_b}, set count=1, go to FILTER (DECODE directly if STABLE_CYCLES=1).
REQ-015 FILTER: seg_valid=0 SHALL abort to IDLE with no pulse. A matching pair SHALL increment count, and reaching STABLE_CYCLES SHALL go to DECODE. A differing pair SHALL relatch and set count=1.
REQ-016 DECODE (one cycle): legal SHALL register amount and pulse amount_valid. Illegal SHALL pulse decode_err with amount unchanged. Either case then goes to HOLD.
REQ-017 HOLD: SHALL produce no further pulses while the latched pair stays present. seg_valid=0 SHALL go to IDLE. A differing pair with seg_valid=1 SHALL relatch, set count=1 and go to FILTER.
REQ-018 Latency: with first sample at edge E1 and matching samples at E1..ES (S=STABLE_CYCLES), the pulse SHALL be registered at edge E(S+1) and be high for exactly one cycle.
REQ-019 amount_valid and decode_err SHALL never be high in the same cycle.
REQ-020 Inputs SHALL be sampled only on clk edges. Changes between edges are ignored.

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, count=0, latched pair=0, amount=0, amount_valid=0, decode_err=0, busy=0, regardless of clk.
REQ-022 Reset asserted mid-FILTER or mid-DECODE SHALL suppress any pending pulse. The first decode after release SHALL require a full STABLE_CYCLES sequence.

Configuration
REQ-023 Macro SEG_STABLE_FILTER_EN defined: FILTER behaviour per REQ-014/015 with STABLE_CYCLES.
REQ-024 Macro SEG_STABLE_FILTER_EN undefined: FILTER SHALL be omitted and STABLE_CYCLES ignored. IDLE/HOLD SHALL latch and go to DECODE directly, so the pulse is registered at E2.

Verification
REQ-025 seg_a=0110000, seg_b=1110000, seg_valid=1 for 3 cycles, S=3 -> amount=17, amount_valid pulse at E4 only.
REQ-026 seg_a=1111001, seg_b=1101101 held (value 32) -> decode_err pulse at E4, amount keeps its prior value.
REQ-027 Pair "0","5" at E1, "0","6" at E2, held through E4 -> count restarts at E2, amount=6 pulse at E5.
REQ-028 seg_valid high E1..E2 then low -> no pulse, busy returns 0, state IDLE.
REQ-029 Legal pair held 10 cycles -> exactly one amount_valid pulse; changing seg_b afterwards starts a new FILTER.
REQ-030 rst pulsed between E2 and E3 of a filter sequence -> all outputs 0 immediately, no pulse; macro undefined -> REQ-025 stimulus pulses at E2.

Source files
------------

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_decoder
// Description : Two-digit seven-segment reader. A {tens, ones} segment pair
//               is debounced over STABLE_CYCLES identical samples and then
//               decoded to a 0..31 amount. Success pulses amount_valid;
//               failure pulses decode_err. Re-decoding happens only after
//               the pair changes or seg_valid drops.
//               Optional feature macro: SEG_STABLE_FILTER_EN
//                 defined   -> stability filter active (STABLE_CYCLES used)
//                 undefined -> filter removed, every new pair is decoded on
//                              the next edge (STABLE_CYCLES ignored)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decoder #(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    input  logic       seg_valid,
    output logic [4:0] amount,
    output logic       amount_valid,
    output logic       decode_err,
    output logic       busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_filter = 2'd1;
    localparam logic [1:0] c_st_decode = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

`ifdef SEG_STABLE_FILTER_EN
    localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);
    // A one-sample filter skips FILTER altogether
    localparam logic [1:0] c_st_after_latch = (c_stable == 4'd1) ? c_st_decode : c_st_filter;
`else
    localparam logic [1:0] c_st_after_latch = c_st_decode;
    // Parameter kept for interface compatibility only
    logic w_unused_cfg;
    assign w_unused_cfg = (STABLE_CYCLES != 0);
`endif

    // Returns {valid, digit}; any pattern outside the ten digits is invalid
    function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
        case (seg)
            7'b1111110: return {1'b1, 4'd0};
            7'b0110000: return {1'b1, 4'd1};
            7'b1101101: return {1'b1, 4'd2};
            7'b1111001: return {1'b1, 4'd3};
            7'b0110011: return {1'b1, 4'd4};
            7'b1011011: return {1'b1, 4'd5};
            7'b1011111: return {1'b1, 4'd6};
            7'b1110000: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1111011: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [13:0] r_pair;
    logic [4:0]  r_amount;
    logic        r_amount_valid;
    logic        r_decode_err;
`ifdef SEG_STABLE_FILTER_EN
    logic [3:0]  r_count;
    logic [3:0]  w_next_count;
`endif

    logic [1:0]  w_next_state;
    logic [13:0] w_next_pair;
    logic [4:0]  w_next_amount;
    logic        w_next_amount_valid;
    logic        w_next_decode_err;

    logic [13:0] w_pair;
    logic        w_same;
    logic [4:0]  w_tens;
    logic [4:0]  w_ones;
    logic [6:0]  w_value;
    logic        w_legal;

    assign w_pair  = {seg_a, seg_b};
    assign w_same  = (w_pair == r_pair);
    assign w_tens  = seg_to_digit(r_pair[13:7]);
    assign w_ones  = seg_to_digit(r_pair[6:0]);
    // 7 bits holds the full 0..99 range so out-of-range values are not aliased
    assign w_value = ({3'b000, w_tens[3:0]} * 7'd10) + {3'b000, w_ones[3:0]};
    assign w_legal = w_tens[4] && w_ones[4] && (w_value <= 7'd31);

    // Next-state, latch, counter and output-pulse logic
    always_comb begin
        w_next_state        = r_state;
        w_next_pair         = r_pair;
        w_next_amount       = r_amount;
        w_next_amount_valid = 1'b0;
        w_next_decode_err   = 1'b0;
`ifdef SEG_STABLE_FILTER_EN
        w_next_count        = r_count;
`endif
        case (r_state)
            c_st_idle: begin
                if (seg_valid) begin
                    w_next_pair  = w_pair;
`ifdef SEG_STABLE_FILTER_EN
                    w_next_count = 4'd1;
`endif
                    w_next_state = c_st_after_latch;
                end
            end
            c_st_filter: begin
`ifdef SEG_STABLE_FILTER_EN
                if (!seg_valid) begin
                    w_next_count = 4'd0;
                    w_next_state = c_st_idle;
                end else if (w_same) begin
                    w_next_count = r_count + 4'd1;
                    if ((r_count + 4'd1) >= c_stable) begin
                        w_next_state = c_st_decode;
                    end
                end else begin
                    w_next_pair  = w_pair;
                    w_next_count = 4'd1;
                end
`else
                w_next_state = c_st_idle;
`endif
            end
            c_st_decode: begin
                if (w_legal) begin
                    w_next_amount       = w_value[4:0];
                    w_next_amount_valid = 1'b1;
                end else begin
                    w_next_decode_err   = 1'b1;
                end
                w_next_state = c_st_hold;
            end
            c_st_hold: begin
                if (!seg_valid) begin
                    w_next_state = c_st_idle;
                end else if (!w_same) begin
                    w_next_pair  = w_pair;
`ifdef SEG_STABLE_FILTER_EN
                    w_next_count = 4'd1;
`endif
                    w_next_state = c_st_after_latch;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // State and output registers; reset clears everything without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_pair         <= 14'd0;
            r_amount       <= 5'd0;
            r_amount_valid <= 1'b0;
            r_decode_err   <= 1'b0;
`ifdef SEG_STABLE_FILTER_EN
            r_count        <= 4'd0;
`endif
        end else begin
            r_state        <= w_next_state;
            r_pair         <= w_next_pair;
            r_amount       <= w_next_amount;
            r_amount_valid <= w_next_amount_valid;
            r_decode_err   <= w_next_decode_err;
`ifdef SEG_STABLE_FILTER_EN
            r_count        <= w_next_count;
`endif
        end
    end

    assign amount       = r_amount;
    assign amount_valid = r_amount_valid;
    assign decode_err   = r_decode_err;
    assign busy         = (r_state == c_st_filter) || (r_state == c_st_decode);

endmodule
`default_nettype wire

// File: tb/tb_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_decoder
// Description : Self-checking bench for seg_decoder. Expected pulses (edge,
//               kind, amount) are queued when a stimulus sequence starts and
//               compared against the DUT as pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_decoder;

    localparam int S = 3;
`ifdef SEG_STABLE_FILTER_EN
    localparam int LAT = S;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int at_edge;
        bit is_err;
        int amt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic       seg_valid;
    logic [4:0] amount;
    logic       amount_valid;
    logic       decode_err;
    logic       busy;

    int   n_total = 0;
    int   n_bad   = 0;
    int   edge_n  = 0;
    int   model_amt = 0;
    exp_t exp_q[$];

    seg_decoder #(
        .STABLE_CYCLES(S)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .seg_a       (seg_a),
        .seg_b       (seg_b),
        .seg_valid   (seg_valid),
        .amount      (amount),
        .amount_valid(amount_valid),
        .decode_err  (decode_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Segment pattern for a digit; -1 gives the blank (invalid) pattern
    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic drive(input int t, input int o, input bit v);
        @(negedge clk);
        seg_a     = pat(t);
        seg_b     = pat(o);
        seg_valid = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b0);
    endtask

    task automatic expect_pulse(input int at, input int t, input int o);
        exp_t e;
        bit   ok;
        ok = (t >= 0) && (o >= 0) && ((t * 10 + o) <= 31);
        e.at_edge = at;
        e.is_err  = !ok;
        if (ok) model_amt = t * 10 + o;
        e.amt = model_amt;
        exp_q.push_back(e);
    endtask

    // Pulse monitor: sampled 1 time unit after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (amount_valid || decode_err) begin
                check_eq("pulse_excl", 32'(amount_valid & decode_err), 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", 32'(amount_valid | decode_err), 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pulse_edge", edge_n, e.at_edge);
                    check_eq("pulse_is_err", 32'(decode_err), 32'(e.is_err));
                    check_eq("pulse_amount", 32'(amount), e.amt);
                end
            end else if (exp_q.size() > 0 && edge_n >= exp_q[0].at_edge) begin
                e = exp_q.pop_front();
                check_eq("pulse_missing", 32'(amount_valid | decode_err), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e1;
        int e2;
        rst       = 1'b1;
        seg_a     = 7'd0;
        seg_b     = 7'd0;
        seg_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_amount", 32'(amount), 0);
        check_eq("rst_amount_valid", 32'(amount_valid), 0);
        check_eq("rst_decode_err", 32'(decode_err), 0);
        check_eq("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(2);

        // "1","7" -> 17
        drive(1, 7, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 1, 7);
        repeat (LAT + 1) drive(1, 7, 1'b1);
        idle(2);

        // "3","2" -> 32 is out of range, amount stays 17
        drive(3, 2, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 3, 2);
        repeat (LAT + 1) drive(3, 2, 1'b1);
        idle(2);

        // "0","5" then "0","6" held -> filter restarts on the change
        drive(0, 5, 1'b1); e1 = edge_n + 1;
        drive(0, 6, 1'b1); e2 = edge_n + 1;
`ifdef SEG_STABLE_FILTER_EN
        expect_pulse(e2 + LAT, 0, 6);
`else
        expect_pulse(e1 + 1, 0, 5);
        expect_pulse(e2 + 2, 0, 6);
`endif
        repeat (LAT + 2) drive(0, 6, 1'b1);
        idle(2);

        // Short burst of two samples, then seg_valid drops
        drive(1, 2, 1'b1); e1 = edge_n + 1;
`ifndef SEG_STABLE_FILTER_EN
        expect_pulse(e1 + 1, 1, 2);
`endif
        drive(1, 2, 1'b1);
        check_eq("busy_after_first", 32'(busy), 1);
        idle(2);
        check_eq("busy_after_abort", 32'(busy), 0);
        idle(1);

        // Upper boundary 31 held 10 cycles, then ones digit changes to 30
        drive(3, 1, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 3, 1);
        repeat (9) drive(3, 1, 1'b1);
        drive(3, 0, 1'b1); e2 = edge_n + 1;
        expect_pulse(e2 + LAT, 3, 0);
        drive(3, 0, 1'b1);
        check_eq("busy_refilter", 32'(busy), 1);
        repeat (LAT + 1) drive(3, 0, 1'b1);
        idle(2);

        // Blank tens digit is invalid
        drive(-1, 5, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, -1, 5);
        repeat (LAT + 1) drive(-1, 5, 1'b1);
        idle(2);

        // Lower boundary 0
        drive(0, 0, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 0, 0);
        repeat (LAT + 1) drive(0, 0, 1'b1);
        idle(2);

        // 40 is out of range, amount stays 0
        drive(4, 0, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 4, 0);
        repeat (LAT + 1) drive(4, 0, 1'b1);
        idle(2);

        // Reset between the 2nd and 3rd samples of a sequence
        drive(2, 4, 1'b1); e1 = edge_n + 1;
`ifndef SEG_STABLE_FILTER_EN
        expect_pulse(e1 + 1, 2, 4);
`endif
        drive(2, 4, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_amt = 0;
        check_eq("midrst_amount", 32'(amount), 0);
        check_eq("midrst_amount_valid", 32'(amount_valid), 0);
        check_eq("midrst_decode_err", 32'(decode_err), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        seg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Full sequence required after reset release
        drive(2, 4, 1'b1); e1 = edge_n + 1;
        expect_pulse(e1 + LAT, 2, 4);
        repeat (LAT + 1) drive(2, 4, 1'b1);
        idle(LAT + 3);

        check_eq("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
